// File: rtl/wb_arb_pkg.sv
// Shared Wishbone arbiter definitions: bus widths, CTI codes and arbiter FSM states.
package wb_arb_pkg;
  localparam int WB_DW = 64;
  localparam int WB_AW = 32;
  localparam int WB_SW = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping modulo N.
module wb_rr_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  int k;

  // scan last+1 .. last+N and keep the first hit
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end else begin
        valid = valid;
      end
    end
  end
endmodule

// File: rtl/wb_ddr2_arbiter.sv
// Wishbone B3 arbiter sharing one DDR2 slave port among NUM_M masters: registered
// round-robin grant, rate-limited high-priority master and a per-grant hang watchdog.
module wb_ddr2_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M   = 5,
  parameter int HP_M    = 4,
  parameter int HP_MAX  = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [NUM_M*WB_AW-1:0] wbm_adr_i,
  input  logic [NUM_M*WB_DW-1:0] wbm_dat_i,
  input  logic [NUM_M*WB_SW-1:0] wbm_sel_i,
  input  logic [NUM_M*3-1:0]     wbm_cti_i,
  input  logic [NUM_M*2-1:0]     wbm_bte_i,
  input  logic [NUM_M-1:0]       wbm_cyc_i,
  input  logic [NUM_M-1:0]       wbm_stb_i,
  input  logic [NUM_M-1:0]       wbm_we_i,
  output logic [WB_DW-1:0]       wbm_dat_o,
  output logic [NUM_M-1:0]       wbm_ack_o,
  output logic [NUM_M-1:0]       wbm_err_o,
  output logic [NUM_M-1:0]       wbm_rty_o,
  output logic [WB_AW-1:0]       wbs_adr_o,
  output logic [WB_DW-1:0]       wbs_dat_o,
  output logic [WB_SW-1:0]       wbs_sel_o,
  output logic [2:0]             wbs_cti_o,
  output logic [1:0]             wbs_bte_o,
  output logic                   wbs_cyc_o,
  output logic                   wbs_stb_o,
  output logic                   wbs_we_o,
  input  logic [WB_DW-1:0]       wbs_dat_i,
  input  logic                   wbs_ack_i,
  output logic [NUM_M-1:0]       grant_o
);
  localparam int IW = $clog2(NUM_M);
  localparam int WW = $clog2(TIMEOUT);
  localparam int HW = $clog2(HP_MAX + 1);
  localparam bit HP_EN  = (HP_M < NUM_M);
  localparam int HP_IDX = HP_EN ? HP_M : 0;
  localparam logic [NUM_M-1:0] HP_MASK = HP_EN ? (NUM_M'(1) << HP_IDX) : NUM_M'(0);

  arb_state_e       state, state_n;
  logic [NUM_M-1:0] grant, grant_n;
  logic [IW-1:0]    gidx, gidx_n;
  logic [IW-1:0]    last, last_n;
  logic [HW-1:0]    hp_run, hp_run_n;
  logic [WW-1:0]    wdog;

  logic [NUM_M-1:0] rr_req, rr_gnt;
  logic [IW-1:0]    rr_idx;
  logic             rr_valid, hp_req, hp_win, g_cyc, fire, drive;

  // The HP master never takes part in the round-robin scan, so 'last' tracks only the others.
  assign rr_req = wbm_cyc_i & ~HP_MASK;
  assign hp_req = |(wbm_cyc_i & HP_MASK);
  assign hp_win = hp_req && ((hp_run < HW'(HP_MAX)) || !(|rr_req));
  assign g_cyc  = wbm_cyc_i[gidx];

  wb_rr_pick #(.N(NUM_M), .IW(IW)) u_pick (
    .req   (rr_req),
    .last  (last),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  // A firing watchdog already blanks the slave side in the same cycle it raises err.
  assign fire  = (state == ST_OWN) && (wdog == WW'(TIMEOUT - 1)) && !wbs_ack_i;
  assign drive = (state == ST_OWN) && !fire;

  assign wbs_cyc_o = drive && g_cyc;
  assign wbs_stb_o = drive && wbm_stb_i[gidx];
  assign wbs_we_o  = drive && wbm_we_i[gidx];
  assign wbs_adr_o = drive ? wbm_adr_i[gidx*WB_AW +: WB_AW] : '0;
  assign wbs_dat_o = drive ? wbm_dat_i[gidx*WB_DW +: WB_DW] : '0;
  assign wbs_sel_o = drive ? wbm_sel_i[gidx*WB_SW +: WB_SW] : '0;
  assign wbs_cti_o = drive ? wbm_cti_i[gidx*3 +: 3] : '0;
  assign wbs_bte_o = drive ? wbm_bte_i[gidx*2 +: 2] : '0;

  assign wbm_ack_o = (state == ST_OWN) ? (grant & {NUM_M{wbs_ack_i}}) : '0;
  assign wbm_err_o = fire ? grant : '0;
  assign wbm_rty_o = '0;
  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant;

  // state, grant and arbitration history registers plus the stb-to-ack watchdog
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      gidx   <= '0;
      last   <= IW'(NUM_M - 1);
      hp_run <= '0;
      wdog   <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      gidx   <= gidx_n;
      last   <= last_n;
      hp_run <= hp_run_n;
      wdog   <= (!wbs_stb_o || wbs_ack_i) ? '0 : wdog + WW'(1);
    end
  end

  // next-state: arbitrate in IDLE, hold the owner until its cyc drops
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    gidx_n   = gidx;
    last_n   = last;
    hp_run_n = hp_run;
    case (state)
      ST_IDLE: begin
        if (hp_win) begin
          state_n  = ST_OWN;
          grant_n  = HP_MASK;
          gidx_n   = IW'(HP_IDX);
          hp_run_n = (hp_run < HW'(HP_MAX)) ? hp_run + HW'(1) : hp_run;
        end else if (rr_valid) begin
          state_n  = ST_OWN;
          grant_n  = rr_gnt;
          gidx_n   = rr_idx;
          last_n   = rr_idx;
          hp_run_n = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (!g_cyc) begin
          state_n = ST_IDLE;
          grant_n = '0;
        end else if (fire) begin
          state_n = ST_ERR;
        end else begin
          state_n = ST_OWN;
        end
      end
      ST_ERR: begin
        if (!g_cyc) begin
          state_n = ST_IDLE;
          grant_n = '0;
        end else begin
          state_n = ST_ERR;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_wb_ddr2_arbiter.sv
// Directed self-checking bench for wb_ddr2_arbiter with a registered-ack memory slave model.
module tb_wb_ddr2_arbiter;
  import wb_arb_pkg::*;
  localparam int NM = 5;

  logic            wb_clk = 1'b0;
  logic            wb_rst = 1'b1;
  logic [NM*32-1:0] wbm_adr_i;
  logic [NM*64-1:0] wbm_dat_i;
  logic [NM*8-1:0]  wbm_sel_i;
  logic [NM*3-1:0]  wbm_cti_i;
  logic [NM*2-1:0]  wbm_bte_i;
  logic [NM-1:0]    wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [63:0]      wbm_dat_o;
  logic [NM-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [31:0]      wbs_adr_o;
  logic [63:0]      wbs_dat_o, wbs_dat_i;
  logic [7:0]       wbs_sel_o;
  logic [2:0]       wbs_cti_o;
  logic [1:0]       wbs_bte_o;
  logic             wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i;

  logic        s_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic        slv_en = 1'b1;
  logic [63:0] s_dat = 64'd0;
  logic [63:0] mem [0:15];
  int n_checks = 0;
  int n_fail = 0;

  wb_ddr2_arbiter #(.NUM_M(NM), .HP_M(4), .HP_MAX(3), .TIMEOUT(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .grant_o(grant_o)
  );

  always #5 wb_clk = ~wb_clk;

  assign wbs_ack_i = s_ack | force_ack;
  assign wbs_dat_i = s_dat;

  // memory slave: acks one cycle after stb, then drops ack for a cycle
  always @(posedge wb_clk) begin
    if (slv_en && wbs_cyc_o && wbs_stb_o && !s_ack) begin
      s_ack <= 1'b1;
      if (wbs_we_o) mem[wbs_adr_o[6:3]] <= wbs_dat_o;
      else s_dat <= mem[wbs_adr_o[6:3]];
    end else begin
      s_ack <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic we, input logic [31:0] adr,
                       input logic [63:0] dat, input logic [2:0] cti);
    wbm_cyc_i[k] = cyc;
    wbm_stb_i[k] = cyc;
    wbm_we_i[k]  = we;
    wbm_adr_i[k*32 +: 32] = adr;
    wbm_dat_i[k*64 +: 64] = dat;
    wbm_cti_i[k*3 +: 3]   = cti;
  endtask

  task automatic idle_all;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i = '0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '1;
    wbm_cti_i = '0; wbm_bte_i = '0;
  endtask

  task automatic do_reset;
    idle_all;
    slv_en = 1'b1;
    force_ack = 1'b0;
    wb_rst = 1'b1;
    tick;
    tick;
    wb_rst = 1'b0;
  endtask

  // masters in 'mask' request continuously, each dropping cyc for one cycle after its ack
  task automatic run_traffic(input logic [NM-1:0] mask, input int want,
                             output int seq [8], output int got, output int bad_gaps);
    logic [NM-1:0] prev;
    int zeros;
    prev = '0; zeros = 0; got = 0; bad_gaps = 0;
    for (int i = 0; i < 8; i++) seq[i] = -1;
    for (int k = 0; k < NM; k++)
      if (mask[k]) set_m(k, 1'b1, 1'b0, 32'(k * 8), 64'd0, CTI_CLASSIC);
    for (int c = 0; c < 200 && got < want; c++) begin
      tick;
      if (grant_o == '0) zeros++;
      else if (prev == '0) begin
        if (got < 8) seq[got] = $clog2(grant_o);
        if (got > 0 && zeros != 1) bad_gaps++;
        got++;
        zeros = 0;
      end
      prev = grant_o;
      for (int k = 0; k < NM; k++)
        if (mask[k]) begin
          wbm_cyc_i[k] = !wbm_ack_o[k];
          wbm_stb_i[k] = !wbm_ack_o[k];
        end
    end
    idle_all;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL reset_grant got %b exp 00000", grant_o); end
    n_checks++; if ({wbs_cyc_o, wbs_stb_o, wbs_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_wbs_ctl got %b exp 000", {wbs_cyc_o, wbs_stb_o, wbs_we_o}); end
    n_checks++; if (wbs_adr_o !== 32'd0) begin n_fail++; $display("FAIL reset_adr got %h exp 0", wbs_adr_o); end
    n_checks++; if (wbm_ack_o !== 5'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 00000", wbm_ack_o); end
    n_checks++; if (wbm_err_o !== 5'b0) begin n_fail++; $display("FAIL reset_err got %b exp 00000", wbm_err_o); end
    n_checks++; if (wbm_rty_o !== 5'b0) begin n_fail++; $display("FAIL reset_rty got %b exp 00000", wbm_rty_o); end
  endtask

  task automatic test_single;
    do_reset;
    set_m(1, 1'b1, 1'b1, 32'h100, 64'hDEADBEEF_CAFEF00D, CTI_CLASSIC);
    tick;
    n_checks++; if (grant_o !== 5'b00010) begin n_fail++; $display("FAIL single_grant got %b exp 00010", grant_o); end
    n_checks++; if (wbs_cyc_o !== 1'b1 || wbs_we_o !== 1'b1) begin n_fail++; $display("FAIL single_cyc got %b%b exp 11", wbs_cyc_o, wbs_we_o); end
    n_checks++; if (wbs_adr_o !== 32'h100) begin n_fail++; $display("FAIL single_adr got %h exp 00000100", wbs_adr_o); end
    n_checks++; if (wbs_sel_o !== 8'hFF) begin n_fail++; $display("FAIL single_sel got %h exp ff", wbs_sel_o); end
    tick;
    n_checks++; if (wbm_ack_o !== 5'b00010) begin n_fail++; $display("FAIL single_wr_ack got %b exp 00010", wbm_ack_o); end
    set_m(1, 1'b0, 1'b0, 32'h0, 64'd0, CTI_CLASSIC);
    tick;
    n_checks++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL single_release got %b exp 00000", grant_o); end
    set_m(1, 1'b1, 1'b0, 32'h100, 64'd0, CTI_CLASSIC);
    tick;
    tick;
    n_checks++; if (wbm_ack_o !== 5'b00010) begin n_fail++; $display("FAIL single_rd_ack got %b exp 00010", wbm_ack_o); end
    n_checks++; if (wbm_dat_o !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL single_rd_data got %h exp deadbeefcafef00d", wbm_dat_o); end
    idle_all;
    tick;
  endtask

  task automatic test_round_robin;
    int seq [8];
    int got, bad;
    int exp_seq [6];
    exp_seq = '{0, 1, 2, 0, 1, 2};
    do_reset;
    run_traffic(5'b00111, 6, seq, got, bad);
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL rr_count got %0d exp 6", got); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rr_gap got %0d bad gaps exp 0", bad); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (seq[i] !== exp_seq[i]) begin n_fail++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, seq[i], exp_seq[i]); end
    end
  endtask

  task automatic test_priority;
    int seq [8];
    int got, bad;
    int exp_seq [8];
    exp_seq = '{4, 4, 4, 0, 4, 4, 4, 0};
    do_reset;
    run_traffic(5'b10001, 8, seq, got, bad);
    n_checks++; if (got !== 8) begin n_fail++; $display("FAIL hp_count got %0d exp 8", got); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hp_gap got %0d bad gaps exp 0", bad); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (seq[i] !== exp_seq[i]) begin n_fail++; $display("FAIL hp_order[%0d] got %0d exp %0d", i, seq[i], exp_seq[i]); end
    end
  endtask

  task automatic test_burst;
    int acks3, other, stolen;
    acks3 = 0; other = 0; stolen = 0;
    do_reset;
    set_m(3, 1'b1, 1'b0, 32'h200, 64'd0, CTI_INCR);
    tick;
    n_checks++; if (grant_o !== 5'b01000) begin n_fail++; $display("FAIL burst_grant got %b exp 01000", grant_o); end
    set_m(0, 1'b1, 1'b0, 32'h300, 64'd0, CTI_CLASSIC);
    for (int c = 0; c < 60 && acks3 < 8; c++) begin
      tick;
      if (grant_o[0]) stolen++;
      if ((wbm_ack_o & 5'b10111) != 5'b0) other++;
      if (wbm_ack_o[3]) begin
        acks3++;
        if (acks3 == 8) begin
          n_checks++; if (wbs_cti_o !== CTI_EOB) begin n_fail++; $display("FAIL burst_eob got %b exp 111", wbs_cti_o); end
          set_m(3, 1'b0, 1'b0, 32'h0, 64'd0, CTI_CLASSIC);
        end else begin
          set_m(3, 1'b1, 1'b0, 32'(32'h200 + acks3 * 8), 64'd0, (acks3 == 7) ? CTI_EOB : CTI_INCR);
        end
      end
    end
    n_checks++; if (acks3 !== 8) begin n_fail++; $display("FAIL burst_acks got %0d exp 8", acks3); end
    n_checks++; if (other !== 0) begin n_fail++; $display("FAIL burst_other_ack got %0d exp 0", other); end
    n_checks++; if (stolen !== 0) begin n_fail++; $display("FAIL burst_stolen got %0d exp 0", stolen); end
    n_checks++; if (wbs_bte_o !== 2'b00) begin n_fail++; $display("FAIL burst_bte got %b exp 00", wbs_bte_o); end
    tick;
    n_checks++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL burst_gap got %b exp 00000", grant_o); end
    tick;
    n_checks++; if (grant_o !== 5'b00001) begin n_fail++; $display("FAIL burst_next got %b exp 00001", grant_o); end
    idle_all;
    tick;
  endtask

  task automatic test_watchdog;
    do_reset;
    slv_en = 1'b0;
    set_m(2, 1'b1, 1'b0, 32'h40, 64'd0, CTI_CLASSIC);
    tick;
    n_checks++; if (grant_o !== 5'b00100) begin n_fail++; $display("FAIL wd_grant got %b exp 00100", grant_o); end
    set_m(1, 1'b1, 1'b0, 32'h80, 64'd0, CTI_CLASSIC);
    repeat (14) tick;
    n_checks++; if (wbm_err_o !== 5'b0) begin n_fail++; $display("FAIL wd_early_err got %b exp 00000", wbm_err_o); end
    n_checks++; if (wbs_stb_o !== 1'b1) begin n_fail++; $display("FAIL wd_early_stb got %b exp 1", wbs_stb_o); end
    tick;
    n_checks++; if (wbm_err_o !== 5'b00100) begin n_fail++; $display("FAIL wd_err got %b exp 00100", wbm_err_o); end
    n_checks++; if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin n_fail++; $display("FAIL wd_force got %b%b exp 00", wbs_cyc_o, wbs_stb_o); end
    tick;
    n_checks++; if (wbm_err_o !== 5'b0) begin n_fail++; $display("FAIL wd_err_pulse got %b exp 00000", wbm_err_o); end
    n_checks++; if (wbs_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wd_err_cyc got %b exp 0", wbs_cyc_o); end
    force_ack = 1'b1;
    #1;
    n_checks++; if (wbm_ack_o !== 5'b0) begin n_fail++; $display("FAIL wd_late_ack got %b exp 00000", wbm_ack_o); end
    force_ack = 1'b0;
    set_m(2, 1'b0, 1'b0, 32'h0, 64'd0, CTI_CLASSIC);
    tick;
    n_checks++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL wd_release got %b exp 00000", grant_o); end
    tick;
    n_checks++; if (grant_o !== 5'b00010) begin n_fail++; $display("FAIL wd_next got %b exp 00010", grant_o); end
    idle_all;
    slv_en = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    set_m(0, 1'b1, 1'b0, 32'h0, 64'd0, CTI_INCR);
    tick;
    tick;
    n_checks++; if (wbm_ack_o !== 5'b00001) begin n_fail++; $display("FAIL rmid_inflight got %b exp 00001", wbm_ack_o); end
    set_m(1, 1'b1, 1'b0, 32'h8, 64'd0, CTI_CLASSIC);
    wb_rst = 1'b1;
    tick;
    n_checks++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL rmid_grant got %b exp 00000", grant_o); end
    n_checks++; if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin n_fail++; $display("FAIL rmid_wbs got %b%b exp 00", wbs_cyc_o, wbs_stb_o); end
    n_checks++; if (wbm_ack_o !== 5'b0) begin n_fail++; $display("FAIL rmid_ack got %b exp 00000", wbm_ack_o); end
    wb_rst = 1'b0;
    tick;
    n_checks++; if (grant_o !== 5'b00001) begin n_fail++; $display("FAIL rmid_restart got %b exp 00001", grant_o); end
    idle_all;
    tick;
  endtask

  initial begin
    idle_all;
    test_reset;
    test_single;
    test_round_robin;
    test_priority;
    test_burst;
    test_watchdog;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
